navre_avr_core: RTL and testbench
=================================

Name: navre_avr_core

Overview:
- Compact 8-bit AVR-subset CPU core for the soft USB controller.
- Fetches 16-bit instructions from external synchronous program memory and uses external synchronous data memory through the X pointer.
- Accesses a 64-location I/O space through IN/OUT strobes.
- Register file r0–r31 and SREG are internal.

Parameters:
pmem_width, 11, program-memory word-address width; PC width.
dmem_width, 13, data-memory byte-address width; X is truncated to this width.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
pmem_ce  out  1  program-memory read enable.
pmem_a  out  pmem_width  program word address.
pmem_d  in  16  instruction word, valid 1 cycle after pmem_ce.
dmem_we  out  1  data-memory write strobe.
dmem_a  out  dmem_width  data address, X[dmem_width-1:0].
dmem_di  in  8  read data, valid 1 cycle after dmem_a is presented.
dmem_do  out  8  write data.
io_re  out  1  I/O read strobe, 1 cycle.
io_we  out  1  I/O write strobe, 1 cycle.
io_a  out  6  I/O address.
io_do  out  8  I/O write data.
io_di  in  8  I/O read data, valid 1 cycle after io_re.

Behaviour:
- Reset, rst=0 at an edge:
  - PC=0, SREG=0, state=STALL.
  - io_re, io_we and dmem_we are 0; pmem_ce=1; pmem_a=0.
  - r0–r31 are not reset.
- Pipeline: at each edge in state NORMAL, the core executes pmem_d and fetches the next word. pmem_a holds the next PC; pmem_ce=1 whenever a fetch is required.
- STALL: one bubble cycle in which pmem_d is ignored (fetch latency). It follows reset and every taken RJMP or branch.
- Decode; Rd/Rr are 5-bit unless noted; K is 8-bit immediate; immediate forms use d = 16 + dddd:
  - NOP 0000.
  - ADD 000011, ADC 000111, SUB 000110, SBC 000010, CP 000101, AND 001000, EOR 001001, OR 001010, MOV 001011 — top 6 bits, then r d dddd rrrr.
  - CPI 0011, SUBI 0101, ORI 0110, ANDI 0111, LDI 1110 — KKKK dddd KKKK.
  - INC 1001010ddddd0011; DEC 1001010ddddd1010.
  - LD Rd,X 1001000ddddd1100; ST X,Rr 1001001rrrrr1100.
  - RJMP 1100 k12: PC = PC + 1 + sign-extended k.
  - BRBS 111100kkkkkkksss / BRBC 111101kkkkkkksss: branch if SREG[s] is set/clear; PC = PC + 1 + sign-extended k7.
  - IN 10110AAdddddAAAA; OUT 10111AArrrrrAAAA.
  - Any other encoding executes as NOP.
- SREG bits: C0 Z1 N2 V3 S4 H5; S = N^V.
  - Add/subtract forms set H, V, N, Z, C per the AVR definition.
  - SBC: Z = Z_old & (result==0).
  - Logic forms: V=0; C and H unchanged.
  - INC/DEC: C and H unchanged; V set on 0x7F→0x80 (INC) and 0x80→0x7F (DEC).
  - MOV, LDI, LD, ST, IN, OUT, jumps: flags unchanged.
  - CP and CPI write flags only, never Rd.
  - All arithmetic is 8-bit with wrap-around.
- OUT: io_we=1 for one cycle, with io_a=A and io_do=Rr in that same cycle. Single-cycle instruction.
- IN: cycle 1 asserts io_re=1 and io_a=A and holds the fetch (pmem_ce=0). Cycle 2 writes io_di into Rd. 2 cycles total.
- ST: dmem_we=1, dmem_a=X, dmem_do=Rr for one cycle. X = {r27,r26}. Single-cycle instruction.
- LD: cycle 1 drives dmem_a=X. Cycle 2 writes dmem_di into Rd. 2 cycles total.
- dmem_a always reflects X when not writing.
- Taken branch or RJMP: 2 cycles (execute + STALL). Not-taken branch: 1 cycle.
- Branch offset wraps modulo 2^pmem_width.
- Reset asserted mid-instruction aborts it; no partial register write occurs on that edge.

Optional Feature:
- Macro NAVRE_MUL_EN adds MUL 100111rdddddrrrr: unsigned Rd*Rr; r1:r0 = 16-bit product; C = product[15]; Z = (product==0). Single cycle.
- Without NAVRE_MUL_EN this encoding executes as NOP.

Test Plan:
- Reset, then program LDI r16,0x05; OUT 0x00,r16 → first io_we pulse carries io_a=0x00, io_do=0x05; no io_we before it.
- LDI r16,0xFF; LDI r17,0x01; ADD r16,r17; BRCS +1 → r16=0x00, C=1, Z=1, H=1; branch taken, next instruction skipped.
- Fibonacci loop (ADD/MOV/DEC/BRBC Z) outputting each term via OUT 0x01 until 233, then OUT 0x00 of 0xFE → IO writes 1,1,2,3,5,…,233, then 0xFE.
- IN r20,0x11 with io_di=0xFF one cycle after io_re → r20=0xFF; exactly one io_re pulse; io_a=0x11.
- X=0x0010; ST X,r5 (r5=0xA5); LD r6,X → dmem write at address 0x10 of 0xA5; r6=0xA5.
- With NAVRE_MUL_EN: r2=200, r3=100, MUL r2,r3 → r1:r0=0x4E20, C=0, Z=0. Without the macro: r0/r1 unchanged.

Source files
------------

// File: rtl/navre_avr_core_if.sv
// Bus bundle for navre_avr_core: program memory, data memory and I/O strobes.
interface navre_avr_core_if #(
    parameter int pmem_width = 11,
    parameter int dmem_width = 13
);
    logic                  pmem_ce;
    logic [pmem_width-1:0] pmem_a;
    logic [15:0]           pmem_d;
    logic                  dmem_we;
    logic [dmem_width-1:0] dmem_a;
    logic [7:0]            dmem_di;
    logic [7:0]            dmem_do;
    logic                  io_re;
    logic                  io_we;
    logic [5:0]            io_a;
    logic [7:0]            io_do;
    logic [7:0]            io_di;

    modport master (
        output pmem_ce, pmem_a, dmem_we, dmem_a, dmem_do, io_re, io_we, io_a, io_do,
        input  pmem_d, dmem_di, io_di
    );

    modport slave (
        input  pmem_ce, pmem_a, dmem_we, dmem_a, dmem_do, io_re, io_we, io_a, io_do,
        output pmem_d, dmem_di, io_di
    );
endinterface

// File: rtl/navre_avr_core.sv
// Compact 8-bit AVR-subset CPU: executes pmem_d while fetching the next word.
// Optional MUL instruction enabled by defining NAVRE_MUL_EN.
module navre_avr_core #(
    parameter int pmem_width = 11,
    parameter int dmem_width = 13
) (
    input  logic             clk,
    input  logic             rst,
    navre_avr_core_if.master bus
);

    typedef enum logic [1:0] {S_STALL, S_NORMAL, S_LOAD, S_IOREAD} state_t;

    typedef struct packed {
        logic [7:0] res;
        logic       h;
        logic       v;
        logic       c;
    } alu_t;

    state_t                r_state;
    logic [pmem_width-1:0] r_pc;
    logic [7:0]            r_sreg;
    logic [4:0]            r_wait_rd;
    logic [7:0]            r_gpr [32];

    logic [15:0]           w_insn;
    logic [4:0]            w_d;
    logic [4:0]            w_r;
    logic [4:0]            w_di;
    logic [7:0]            w_k;
    logic [7:0]            w_rd_val;
    logic [7:0]            w_rr_val;
    logic [7:0]            w_rdi_val;
    logic [pmem_width-1:0] w_pc_inc;

    logic                  w_rf_we;
    logic [4:0]            w_rf_wa;
    logic [7:0]            w_rf_wd;
    logic                  w_mul_we;
    logic [15:0]           w_prod;
    logic [7:0]            w_sreg_next;
    logic                  w_is_ld;
    logic                  w_is_st;
    logic                  w_is_in;
    logic                  w_is_out;
    logic                  w_taken;
    logic [pmem_width-1:0] w_target;
    alu_t                  w_alu;
    logic [7:0]            w_res;

    function automatic alu_t f_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
        alu_t o;
        o.res = a + b + {7'd0, cin};
        o.h   = (a[3] & b[3]) | (b[3] & ~o.res[3]) | (~o.res[3] & a[3]);
        o.v   = (a[7] & b[7] & ~o.res[7]) | (~a[7] & ~b[7] & o.res[7]);
        o.c   = (a[7] & b[7]) | (b[7] & ~o.res[7]) | (~o.res[7] & a[7]);
        return o;
    endfunction

    function automatic alu_t f_sub(input logic [7:0] a, input logic [7:0] b, input logic cin);
        alu_t o;
        o.res = a - b - {7'd0, cin};
        o.h   = (~a[3] & b[3]) | (b[3] & o.res[3]) | (o.res[3] & ~a[3]);
        o.v   = (a[7] & ~b[7] & ~o.res[7]) | (~a[7] & b[7] & o.res[7]);
        o.c   = (~a[7] & b[7]) | (b[7] & o.res[7]) | (o.res[7] & ~a[7]);
        return o;
    endfunction

    // SREG layout: {-, -, H, S, V, N, Z, C}
    function automatic logic [7:0] f_flags(input logic [7:0] old, input logic h, input logic v,
                                           input logic n, input logic z, input logic c);
        return {old[7:6], h, n ^ v, v, n, z, c};
    endfunction

    assign w_insn    = bus.pmem_d;
    assign w_d       = w_insn[8:4];
    assign w_r       = {w_insn[9], w_insn[3:0]};
    assign w_di      = {1'b1, w_insn[7:4]};
    assign w_k       = {w_insn[11:8], w_insn[3:0]};
    assign w_rd_val  = r_gpr[w_d];
    assign w_rr_val  = r_gpr[w_r];
    assign w_rdi_val = r_gpr[w_di];
    assign w_pc_inc  = r_pc + pmem_width'(1);

    always_comb begin
        w_rf_we     = 1'b0;
        w_rf_wa     = w_d;
        w_rf_wd     = '0;
        w_mul_we    = 1'b0;
        w_prod      = '0;
        w_sreg_next = r_sreg;
        w_is_ld     = 1'b0;
        w_is_st     = 1'b0;
        w_is_in     = 1'b0;
        w_is_out    = 1'b0;
        w_taken     = 1'b0;
        w_target    = w_pc_inc;
        w_alu       = '0;
        w_res       = '0;
        if (r_state == S_LOAD) begin
            w_rf_we = 1'b1;
            w_rf_wa = r_wait_rd;
            w_rf_wd = bus.dmem_di;
        end else if (r_state == S_IOREAD) begin
            w_rf_we = 1'b1;
            w_rf_wa = r_wait_rd;
            w_rf_wd = bus.io_di;
        end else if (r_state == S_NORMAL) begin
            casez (w_insn)
                16'b000011??????????, 16'b000111??????????: begin  // ADD, ADC
                    w_alu       = f_add(w_rd_val, w_rr_val, w_insn[12] & r_sreg[0]);
                    w_rf_we     = 1'b1;
                    w_rf_wd     = w_alu.res;
                    w_sreg_next = f_flags(r_sreg, w_alu.h, w_alu.v, w_alu.res[7],
                                          w_alu.res == 8'h00, w_alu.c);
                end
                16'b000110??????????, 16'b000101??????????: begin  // SUB, CP
                    w_alu       = f_sub(w_rd_val, w_rr_val, 1'b0);
                    w_rf_we     = w_insn[11];
                    w_rf_wd     = w_alu.res;
                    w_sreg_next = f_flags(r_sreg, w_alu.h, w_alu.v, w_alu.res[7],
                                          w_alu.res == 8'h00, w_alu.c);
                end
                16'b000010??????????: begin  // SBC: Z can only stay set
                    w_alu       = f_sub(w_rd_val, w_rr_val, r_sreg[0]);
                    w_rf_we     = 1'b1;
                    w_rf_wd     = w_alu.res;
                    w_sreg_next = f_flags(r_sreg, w_alu.h, w_alu.v, w_alu.res[7],
                                          r_sreg[1] & (w_alu.res == 8'h00), w_alu.c);
                end
                16'b001000??????????, 16'b001001??????????, 16'b001010??????????: begin
                    unique case (w_insn[11:10])
                        2'b00:   w_res = w_rd_val & w_rr_val;
                        2'b01:   w_res = w_rd_val ^ w_rr_val;
                        default: w_res = w_rd_val | w_rr_val;
                    endcase
                    w_rf_we     = 1'b1;
                    w_rf_wd     = w_res;
                    w_sreg_next = f_flags(r_sreg, r_sreg[5], 1'b0, w_res[7],
                                          w_res == 8'h00, r_sreg[0]);
                end
                16'b001011??????????: begin  // MOV
                    w_rf_we = 1'b1;
                    w_rf_wd = w_rr_val;
                end
                16'b0011????????????, 16'b0101????????????: begin  // CPI, SUBI
                    w_alu       = f_sub(w_rdi_val, w_k, 1'b0);
                    w_rf_we     = w_insn[14];
                    w_rf_wa     = w_di;
                    w_rf_wd     = w_alu.res;
                    w_sreg_next = f_flags(r_sreg, w_alu.h, w_alu.v, w_alu.res[7],
                                          w_alu.res == 8'h00, w_alu.c);
                end
                16'b0110????????????, 16'b0111????????????: begin  // ORI, ANDI
                    w_res       = w_insn[12] ? (w_rdi_val & w_k) : (w_rdi_val | w_k);
                    w_rf_we     = 1'b1;
                    w_rf_wa     = w_di;
                    w_rf_wd     = w_res;
                    w_sreg_next = f_flags(r_sreg, r_sreg[5], 1'b0, w_res[7],
                                          w_res == 8'h00, r_sreg[0]);
                end
                16'b1110????????????: begin  // LDI
                    w_rf_we = 1'b1;
                    w_rf_wa = w_di;
                    w_rf_wd = w_k;
                end
                16'b1001010?????0011: begin  // INC
                    w_res       = w_rd_val + 8'd1;
                    w_rf_we     = 1'b1;
                    w_rf_wd     = w_res;
                    w_sreg_next = f_flags(r_sreg, r_sreg[5], w_rd_val == 8'h7F, w_res[7],
                                          w_res == 8'h00, r_sreg[0]);
                end
                16'b1001010?????1010: begin  // DEC
                    w_res       = w_rd_val - 8'd1;
                    w_rf_we     = 1'b1;
                    w_rf_wd     = w_res;
                    w_sreg_next = f_flags(r_sreg, r_sreg[5], w_rd_val == 8'h80, w_res[7],
                                          w_res == 8'h00, r_sreg[0]);
                end
                16'b1001000?????1100: w_is_ld  = 1'b1;
                16'b1001001?????1100: w_is_st  = 1'b1;
                16'b10110???????????: w_is_in  = 1'b1;
                16'b10111???????????: w_is_out = 1'b1;
                16'b1100????????????: begin  // RJMP
                    w_taken  = 1'b1;
                    w_target = w_pc_inc + pmem_width'($signed(w_insn[11:0]));
                end
                16'b11110???????????: begin  // BRBS / BRBC
                    w_taken  = r_sreg[w_insn[2:0]] ^ w_insn[10];
                    w_target = w_pc_inc + pmem_width'($signed(w_insn[9:3]));
                end
`ifdef NAVRE_MUL_EN
                16'b100111??????????: begin  // MUL
                    w_prod      = w_rd_val * w_rr_val;
                    w_mul_we    = 1'b1;
                    w_sreg_next = {r_sreg[7:2], w_prod == 16'h0000, w_prod[15]};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_STALL;
            r_pc      <= '0;
            r_sreg    <= '0;
            r_wait_rd <= '0;
        end else begin
            r_sreg <= w_sreg_next;
            unique case (r_state)
                S_NORMAL: begin
                    r_wait_rd <= w_d;
                    if (w_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_STALL;
                    end else begin
                        r_pc <= w_pc_inc;
                        if (w_is_ld)
                            r_state <= S_LOAD;
                        else if (w_is_in)
                            r_state <= S_IOREAD;
                    end
                end
                default: r_state <= S_NORMAL;
            endcase
        end
    end

    // r0..r31 are deliberately left out of reset; rst only blocks the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_mul_we) begin
                r_gpr[0] <= w_prod[7:0];
                r_gpr[1] <= w_prod[15:8];
            end else if (w_rf_we) begin
                r_gpr[w_rf_wa] <= w_rf_wd;
            end
        end
    end

    // Outside NORMAL the fetch pointer already addresses the next instruction.
    always_comb begin
        bus.pmem_ce = 1'b1;
        bus.pmem_a  = r_pc;
        if (!rst) begin
            bus.pmem_a = '0;
        end else if (r_state == S_NORMAL) begin
            bus.pmem_a  = w_taken ? w_target : w_pc_inc;
            bus.pmem_ce = ~(w_taken | w_is_ld | w_is_in);
        end
    end

    assign bus.dmem_we = rst & w_is_st;
    assign bus.dmem_a  = dmem_width'({r_gpr[27], r_gpr[26]});
    assign bus.dmem_do = w_rd_val;
    assign bus.io_re   = rst & w_is_in;
    assign bus.io_we   = rst & w_is_out;
    assign bus.io_a    = {w_insn[10:9], w_insn[3:0]};
    assign bus.io_do   = w_rd_val;

endmodule

// File: tb/tb_navre_avr_core.sv
// Directed-program bench for navre_avr_core; observes results through OUT writes and dmem traffic.
module tb_navre_avr_core;

    logic clk;
    logic rst;

    navre_avr_core_if #(.pmem_width(11), .dmem_width(13)) bus ();

    navre_avr_core #(.pmem_width(11), .dmem_width(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] pmem [2048];
    logic [7:0]  dmem [8192];
    logic [13:0] io_log [$];
    logic [20:0] dm_log [$];
    logic [13:0] exp_io [$];
    int          pc_ld;
    int          re_cnt;
    logic [5:0]  re_a;
    logic        re_ce;
    int          n_tests;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.pmem_ce) bus.pmem_d <= pmem[bus.pmem_a];
        if (bus.dmem_we) dmem[bus.dmem_a] <= bus.dmem_do;
        bus.dmem_di <= dmem[bus.dmem_a];
        bus.io_di   <= (bus.io_re && bus.io_a == 6'h11) ? 8'hFF : 8'h00;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.io_we)   io_log.push_back({bus.io_a, bus.io_do});
            if (bus.dmem_we) dm_log.push_back({bus.dmem_a, bus.dmem_do});
            if (bus.io_re) begin
                re_cnt++;
                re_a  = bus.io_a;
                re_ce = bus.pmem_ce;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] f_ldi(input int d, input int k);
        return {4'hE, 4'(k >> 4), 4'(d - 16), 4'(k)};
    endfunction
    function automatic logic [15:0] f_imm(input int op, input int d, input int k);
        return {4'(op), 4'(k >> 4), 4'(d - 16), 4'(k)};
    endfunction
    function automatic logic [15:0] f_2op(input int op, input int d, input int r);
        return {6'(op), 1'(r >> 4), 5'(d), 4'(r)};
    endfunction
    function automatic logic [15:0] f_one(input int hi, input int d, input int lo);
        return {7'(hi), 5'(d), 4'(lo)};
    endfunction
    function automatic logic [15:0] f_out(input int a, input int r);
        return {5'b10111, 2'(a >> 4), 5'(r), 4'(a)};
    endfunction
    function automatic logic [15:0] f_in(input int d, input int a);
        return {5'b10110, 2'(a >> 4), 5'(d), 4'(a)};
    endfunction
    function automatic logic [15:0] f_br(input int clr, input int s, input int k);
        return {5'b11110, 1'(clr), 7'(k), 3'(s)};
    endfunction
    function automatic logic [15:0] f_rjmp(input int k);
        return {4'hC, 12'(k)};
    endfunction

    task automatic put(input logic [15:0] w);
        pmem[pc_ld] = w;
        pc_ld++;
    endtask

    task automatic expect_io(input int a, input int d);
        exp_io.push_back({6'(a), 8'(d)});
    endtask

    task automatic load_start();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
        pc_ld = 0;
        io_log.delete();
        dm_log.delete();
        exp_io.delete();
        re_cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input string tag, input int cycles);
        rst = 1'b1;
        #1;
        check({tag, " pc after reset"}, 32'(bus.pmem_a), 32'h0);
        check({tag, " ce after reset"}, 32'(bus.pmem_ce), 32'h1);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_io(input string tag);
        logic [31:0] got;
        check({tag, " io write count"}, 32'(io_log.size()), 32'(exp_io.size()));
        for (int i = 0; i < exp_io.size(); i++) begin
            got = (i < io_log.size()) ? 32'(io_log[i]) : 32'hDEAD;
            check($sformatf("%s io[%0d]", tag, i), got, 32'(exp_io[i]));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        for (int i = 0; i < 8192; i++) dmem[i] = 8'h00;

        // reset state
        load_start();
        check("rst pmem_ce", 32'(bus.pmem_ce), 32'h1);
        check("rst pmem_a", 32'(bus.pmem_a), 32'h0);
        check("rst io_we", 32'(bus.io_we), 32'h0);
        check("rst io_re", 32'(bus.io_re), 32'h0);
        check("rst dmem_we", 32'(bus.dmem_we), 32'h0);

        // LDI + OUT
        put(f_ldi(16, 8'h05));
        put(f_out(0, 16));
        put(f_rjmp(-1));
        expect_io(8'h00, 8'h05);
        run("ldi_out", 40);
        check_io("ldi_out");

        // ADD flags, taken and not-taken branches
        load_start();
        put(f_ldi(16, 8'hFF));
        put(f_ldi(17, 8'h01));
        put(f_2op(6'b000011, 16, 17));
        put(f_br(0, 0, 1));
        put(f_out(8'h3E, 17));
        put(f_br(0, 1, 1));
        put(f_out(8'h3E, 17));
        put(f_br(0, 5, 1));
        put(f_out(8'h3E, 17));
        put(f_br(1, 0, 1));
        put(f_out(8'h03, 17));
        put(f_out(8'h02, 16));
        put(f_rjmp(-1));
        expect_io(8'h03, 8'h01);
        expect_io(8'h02, 8'h00);
        run("add_br", 60);
        check_io("add_br");

        // Fibonacci loop
        load_start();
        put(f_ldi(16, 1));
        put(f_ldi(17, 1));
        put(f_ldi(18, 13));
        put(f_out(8'h01, 16));
        put(f_2op(6'b001011, 19, 16));
        put(f_2op(6'b000011, 19, 17));
        put(f_2op(6'b001011, 16, 17));
        put(f_2op(6'b001011, 17, 19));
        put(f_one(7'b1001010, 18, 4'hA));
        put(f_br(1, 1, -7));
        put(f_ldi(20, 8'hFE));
        put(f_out(8'h00, 20));
        put(f_rjmp(-1));
        foreach (exp_io[i]) ;
        expect_io(1, 1);   expect_io(1, 1);   expect_io(1, 2);   expect_io(1, 3);
        expect_io(1, 5);   expect_io(1, 8);   expect_io(1, 13);  expect_io(1, 21);
        expect_io(1, 34);  expect_io(1, 55);  expect_io(1, 89);  expect_io(1, 144);
        expect_io(1, 233); expect_io(0, 8'hFE);
        run("fib", 400);
        check_io("fib");

        // IN
        load_start();
        put(f_ldi(20, 8'h00));
        put(f_in(20, 8'h11));
        put(f_out(8'h04, 20));
        put(f_rjmp(-1));
        expect_io(8'h04, 8'hFF);
        run("in", 40);
        check_io("in");
        check("in io_re pulses", 32'(re_cnt), 32'd1);
        check("in io_a", 32'(re_a), 32'h11);
        check("in fetch held", 32'(re_ce), 32'h0);

        // ST / LD through X
        load_start();
        put(f_ldi(16, 8'hA5));
        put(f_2op(6'b001011, 5, 16));
        put(f_ldi(26, 8'h10));
        put(f_ldi(27, 8'h00));
        put(f_one(7'b1001001, 5, 4'hC));
        put(f_one(7'b1001000, 6, 4'hC));
        put(f_out(8'h05, 6));
        put(f_rjmp(-1));
        expect_io(8'h05, 8'hA5);
        run("st_ld", 40);
        check_io("st_ld");
        check("st count", 32'(dm_log.size()), 32'd1);
        check("st addr/data", (dm_log.size() > 0) ? 32'(dm_log[0]) : 32'hDEAD, {11'd0, 13'h0010, 8'hA5});

        // MUL (or NOP when the option is absent)
        load_start();
        put(f_ldi(16, 200));
        put(f_2op(6'b001011, 2, 16));
        put(f_ldi(16, 100));
        put(f_2op(6'b001011, 3, 16));
        put(f_ldi(16, 8'h11));
        put(f_2op(6'b001011, 0, 16));
        put(f_2op(6'b001011, 1, 16));
        put(f_2op(6'b100111, 2, 3));
        put(f_out(8'h06, 0));
        put(f_out(8'h07, 1));
        put(f_br(1, 0, 1));
        put(f_out(8'h3E, 0));
        put(f_br(1, 1, 1));
        put(f_out(8'h3E, 0));
        put(f_rjmp(-1));
`ifdef NAVRE_MUL_EN
        expect_io(8'h06, 8'h20);
        expect_io(8'h07, 8'h4E);
`else
        expect_io(8'h06, 8'h11);
        expect_io(8'h07, 8'h11);
`endif
        run("mul", 60);
        check_io("mul");

        // INC overflow, SUBI borrow, CPI, logic immediates
        load_start();
        put(f_ldi(16, 8'h7F));
        put(f_one(7'b1001010, 16, 4'h3));
        put(f_br(0, 3, 1));
        put(f_out(8'h3E, 16));
        put(f_out(8'h09, 16));
        put(f_ldi(17, 8'h10));
        put(f_imm(4'b0101, 17, 8'h11));
        put(f_br(0, 0, 1));
        put(f_out(8'h3E, 17));
        put(f_br(0, 5, 1));
        put(f_out(8'h3E, 17));
        put(f_imm(4'b0011, 17, 8'hFF));
        put(f_br(0, 1, 1));
        put(f_out(8'h3E, 17));
        put(f_out(8'h0A, 17));
        put(f_ldi(18, 8'hF0));
        put(f_imm(4'b0110, 18, 8'h0F));
        put(f_imm(4'b0111, 18, 8'h3C));
        put(f_2op(6'b001001, 18, 17));
        put(f_out(8'h0B, 18));
        put(f_rjmp(-1));
        expect_io(8'h09, 8'h80);
        expect_io(8'h0A, 8'hFF);
        expect_io(8'h0B, 8'hC3);
        run("flags", 80);
        check_io("flags");

        // RJMP backwards past address 0 wraps to the top of program memory
        load_start();
        put(f_ldi(16, 8'h77));
        put(f_rjmp(-3));
        pmem[2047] = f_out(8'h08, 16);
        run("wrap", 20);
        check("wrap first io", (io_log.size() > 0) ? 32'(io_log[0]) : 32'hDEAD, {18'd0, 6'h08, 8'h77});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
